ula_arbiter: RTL and testbench

ULA_ARBITER -- requirements
Module: ula_arbiter

---
 rtl/ula_arbiter_pkg.sv | 31 +++
 rtl/ula_arbiter_ula.sv | 31 +++
 rtl/ula_arbiter.sv | 178 +++++++++++++++++
 tb/tb_ula_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ula_arbiter_pkg.sv
// ula_arbiter_pkg
// Shared definitions for the ALU arbiter slice:
//   - ALU opcode constants (AND, OR, ADD, SUB, SLT, NAND)
//   - FSM state encoding for the response register
//   - op_is_legal(): opcode legality check used outside the ALU
package ula_arbiter_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NAND = 4'b1100;

    // IDLE: response register empty; HOLD: response valid, waiting for rsp_ready
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NAND: legal = 1'b1;
            default:                                        legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/ula_arbiter_ula.sv
// ula_arbiter_ula -- the ULA: purely combinational ALU.
// Ports:
//   a, b    : WIDTH-bit operands
//   op      : 4-bit opcode (see ula_arbiter_pkg)
//   result  : WIDTH-bit result; 0 for opcodes it does not implement
// Add/sub wrap modulo 2^WIDTH; SLT is an unsigned compare returning 1/0.
module ula_arbiter_ula
    import ula_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_NAND: result = ~(a & b);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/ula_arbiter.sv
// ula_arbiter -- shares one ULA between requester 0 (main datapath) and
// requester 1 (branch/address unit) with round-robin arbitration and a
// single registered response slot.
// Ports:
//   clk, reset                       : clock, asynchronous active-high reset
//   rN_valid / rN_ready              : request handshake per requester
//   rN_in1, rN_in2, rN_op            : request payload
//   rsp_valid / rsp_ready            : response handshake
//   rsp_id, rsp_result, rsp_zero,
//   rsp_err                          : response payload (source, result, zero flag, illegal op)
//   cnt0, cnt1                       : saturating accepted-request counters
// Latency is one cycle; with rsp_ready held high a request can be accepted
// every cycle because a draining response frees the slot in the same cycle.
module ula_arbiter
    import ula_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_in1,
    input  logic [WIDTH-1:0] r0_in2,
    input  logic [3:0]       r0_op,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_in1,
    input  logic [WIDTH-1:0] r1_in2,
    input  logic [3:0]       r1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_reg, state_next;
    logic             ptr_reg;          // 1 = requester 1 wins a tie
    logic             can_accept;
    logic [1:0]       valid_vec;
    logic [1:0]       grant;
    logic             accept;
    logic             sel;
    logic [WIDTH-1:0] sel_in1, sel_in2;
    logic [3:0]       sel_op;
    logic [WIDTH-1:0] alu_result;
    logic             op_legal;
    logic [WIDTH-1:0] result_next;

    logic             rsp_id_reg;
    logic [WIDTH-1:0] rsp_result_reg;
    logic             rsp_zero_reg;
    logic             rsp_err_reg;

    assign valid_vec = {r1_valid, r0_valid};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state and outputs ----------------
    always_comb begin
        state_next = state_reg;
        rsp_valid  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) state_next = ST_HOLD;
            end
            ST_HOLD: begin
                rsp_valid = 1'b1;
                // A simultaneous accept refills the slot, so stay in HOLD.
                if (rsp_ready && !accept) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The slot is free when empty or when its content leaves this cycle.
    assign can_accept = (state_reg == ST_IDLE) || (rsp_valid && rsp_ready);

    // ---------------- Arbitration ----------------
    // Reset gates the readys combinationally so nothing is acknowledged
    // while reset is held, even mid-cycle.
    always_comb begin
        grant = 2'b00;
        if (can_accept && !reset) begin
            if (&valid_vec) begin
                grant = ptr_reg ? 2'b10 : 2'b01;
            end else begin
                grant = valid_vec;
            end
        end
    end

    assign r0_ready = grant[0];
    assign r1_ready = grant[1];
    assign accept   = |grant;
    assign sel      = grant[1];

    // Pointer moves only on acceptance, to favour the requester not just served.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_reg <= 1'b0;
        end else if (accept) begin
            ptr_reg <= ~sel;
        end
    end

    // ---------------- Datapath ----------------
    assign sel_in1 = sel ? r1_in1 : r0_in1;
    assign sel_in2 = sel ? r1_in2 : r0_in2;
    assign sel_op  = sel ? r1_op  : r0_op;

    ula_arbiter_ula #(
        .WIDTH (WIDTH)
    ) u_ula (
        .a      (sel_in1),
        .b      (sel_in2),
        .op     (sel_op),
        .result (alu_result)
    );

    assign op_legal    = op_is_legal(sel_op);
    assign result_next = op_legal ? alu_result : '0;

    // Response payload is written only on acceptance, so it stays stable
    // while the consumer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_id_reg     <= 1'b0;
            rsp_result_reg <= '0;
            rsp_zero_reg   <= 1'b0;
            rsp_err_reg    <= 1'b0;
        end else if (accept) begin
            rsp_id_reg     <= sel;
            rsp_result_reg <= result_next;
            rsp_zero_reg   <= (result_next == '0);
            rsp_err_reg    <= ~op_legal;
        end
    end

    assign rsp_id     = rsp_id_reg;
    assign rsp_result = rsp_result_reg;
    assign rsp_zero   = rsp_zero_reg;
    assign rsp_err    = rsp_err_reg;

    // ---------------- Saturating per-requester counters ----------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (grant[gi] && (cnt_reg != CNT_MAX)) begin
                    cnt_reg <= cnt_reg + CNT_ONE;
                end
            end
        end
    endgenerate

    assign cnt0 = g_cnt[0].cnt_reg;
    assign cnt1 = g_cnt[1].cnt_reg;

endmodule

// File: tb/tb_ula_arbiter.sv
// Directed testbench for ula_arbiter. Inputs change on the falling edge;
// combinational readys are checked 1 ns later and registered outputs are
// checked on the next falling edge. Counters use a 4-bit width so that
// saturation is reachable in a few cycles.
module tb_ula_arbiter;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             r0_valid, r1_valid;
    logic             r0_ready, r1_ready;
    logic [WIDTH-1:0] r0_in1, r0_in2, r1_in1, r1_in2;
    logic [3:0]       r0_op, r1_op;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
    logic [WIDTH-1:0] rsp_result;
    logic [CNT_W-1:0] cnt0, cnt1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ula_arbiter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .r0_valid   (r0_valid),
        .r0_ready   (r0_ready),
        .r0_in1     (r0_in1),
        .r0_in2     (r0_in2),
        .r0_op      (r0_op),
        .r1_valid   (r1_valid),
        .r1_ready   (r1_ready),
        .r1_in1     (r1_in1),
        .r1_in2     (r1_in2),
        .r1_op      (r1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        r0_valid = v; r0_in1 = a; r0_in2 = b; r0_op = op;
    endtask

    task automatic req1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        r1_valid = v; r1_in1 = a; r1_in2 = b; r1_op = op;
    endtask

    task automatic chk_rsp(input string tag, input logic id, input logic [31:0] res,
                           input logic zero, input logic err);
        chk({tag, ".valid"},  rsp_valid,  1'b1);
        chk({tag, ".id"},     rsp_id,     id);
        chk({tag, ".result"}, rsp_result, res);
        chk({tag, ".zero"},   rsp_zero,   zero);
        chk({tag, ".err"},    rsp_err,    err);
        $display("txn %s: id=%0d result=%08h zero=%0b err=%0b cnt0=%0d cnt1=%0d",
                 tag, rsp_id, rsp_result, rsp_zero, rsp_err, cnt0, cnt1);
    endtask

    // op, in1, in2, expected result, expected err
    logic [3:0]  t_op  [8] = '{4'h7, 4'h2, 4'h7, 4'h6, 4'hC, 4'h0, 4'h1, 4'h3};
    logic [31:0] t_a   [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'h3, 32'hFFFFFFFF,
                               32'hF0F0F0F0, 32'hF0F0F0F0, 32'h1};
    logic [31:0] t_b   [8] = '{32'h1, 32'h1, 32'hFFFFFFFF, 32'h5, 32'h0000FFFF,
                               32'hFF00FF00, 32'h0F0F0000, 32'h1};
    logic [31:0] t_exp [8] = '{32'h0, 32'h0, 32'h1, 32'hFFFFFFFE, 32'hFFFF0000,
                               32'hF000F000, 32'hFFFFF0F0, 32'h0};
    logic        t_err [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        reset = 1'b1;
        rsp_ready = 1'b0;
        req0(1'b1, 32'd5, 32'd3, 4'h2);   // valid during reset must not be acknowledged
        req1(1'b0, '0, '0, 4'h0);

        // ---- reset state ----
        @(negedge clk);
        @(negedge clk);
        chk("rst.rsp_valid", rsp_valid, 1'b0);
        chk("rst.rsp_id", rsp_id, 1'b0);
        chk("rst.rsp_result", rsp_result, 32'h0);
        chk("rst.rsp_zero", rsp_zero, 1'b0);
        chk("rst.rsp_err", rsp_err, 1'b0);
        chk("rst.cnt0", cnt0, 4'd0);
        chk("rst.cnt1", cnt1, 4'd0);
        chk("rst.r0_ready", r0_ready, 1'b0);
        reset = 1'b0;
        req0(1'b0, '0, '0, 4'h0);

        // ---- single r0 add 5+3 ----
        @(negedge clk);
        rsp_ready = 1'b1;
        req0(1'b1, 32'd5, 32'd3, 4'h2);
        #1;
        chk("add.r0_ready", r0_ready, 1'b1);
        chk("add.r1_ready", r1_ready, 1'b0);
        @(negedge clk);
        req0(1'b0, '0, '0, 4'h0);
        chk_rsp("add", 1'b0, 32'd8, 1'b0, 1'b0);
        chk("add.cnt0", cnt0, 4'd1);

        // ---- round robin after a fresh reset ----
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req0(1'b1, 32'd1, 32'd1, 4'h2);                 // -> 2
        req1(1'b1, 32'h000000F0, 32'h0000000F, 4'h1);   // -> FF
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr%0d.r0_ready", k), r0_ready, (k % 2) == 0);
            chk($sformatf("rr%0d.r1_ready", k), r1_ready, (k % 2) == 1);
            @(negedge clk);
            chk_rsp($sformatf("rr%0d", k), (k % 2) == 1,
                    ((k % 2) == 0) ? 32'h2 : 32'hFF, 1'b0, 1'b0);
        end
        req0(1'b0, '0, '0, 4'h0);
        req1(1'b0, '0, '0, 4'h0);
        chk("rr.cnt0", cnt0, 4'd2);
        chk("rr.cnt1", cnt1, 4'd2);

        // ---- backpressure: r1 sub 7-7 held for 3 cycles ----
        @(negedge clk);
        chk("drain.rsp_valid", rsp_valid, 1'b0);
        rsp_ready = 1'b0;
        req1(1'b1, 32'd7, 32'd7, 4'h6);
        #1;
        chk("sub.r1_ready", r1_ready, 1'b1);
        @(negedge clk);
        req1(1'b0, '0, '0, 4'h0);
        req0(1'b1, 32'hC, 32'hA, 4'h0);                 // pending AND -> 8
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("hold%0d.r0_ready", k), r0_ready, 1'b0);
            chk($sformatf("hold%0d.r1_ready", k), r1_ready, 1'b0);
            chk_rsp($sformatf("hold%0d", k), 1'b1, 32'h0, 1'b1, 1'b0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        chk("release.r0_ready", r0_ready, 1'b1);
        @(negedge clk);
        req0(1'b0, '0, '0, 4'h0);
        chk_rsp("release", 1'b0, 32'h8, 1'b0, 1'b0);
        chk("release.cnt0", cnt0, 4'd3);
        chk("release.cnt1", cnt1, 4'd3);

        // ---- illegal opcode ----
        @(negedge clk);
        req0(1'b1, 32'd5, 32'd3, 4'hF);
        #1;
        chk("ill.r0_ready", r0_ready, 1'b1);
        @(negedge clk);
        chk_rsp("ill", 1'b0, 32'h0, 1'b1, 1'b1);
        chk("ill.cnt0", cnt0, 4'd4);

        // ---- opcode table, back to back on r0 ----
        for (int k = 0; k < 8; k++) begin
            req0(1'b1, t_a[k], t_b[k], t_op[k]);
            #1;
            chk($sformatf("op%0d.r0_ready", k), r0_ready, 1'b1);
            @(negedge clk);
            chk_rsp($sformatf("op%0d", k), 1'b0, t_exp[k], t_exp[k] == 32'h0, t_err[k]);
        end
        chk("ops.cnt0", cnt0, 4'd12);

        // ---- saturation: 5 more accepts from 12 stop at 15 ----
        req0(1'b1, 32'd1, 32'd2, 4'h2);
        for (int k = 0; k < 5; k++) @(negedge clk);
        req0(1'b0, '0, '0, 4'h0);
        chk("sat.cnt0", cnt0, 4'd15);
        chk("sat.cnt1", cnt1, 4'd3);

        // ---- reset while holding a response ----
        @(negedge clk);
        rsp_ready = 1'b0;
        req1(1'b1, 32'd2, 32'd2, 4'h2);
        @(negedge clk);
        req1(1'b0, '0, '0, 4'h0);
        chk_rsp("prerst", 1'b1, 32'd4, 1'b0, 1'b0);
        req0(1'b1, 32'd6, 32'd1, 4'h6);
        reset = 1'b1;
        #1;
        chk("midrst.rsp_valid", rsp_valid, 1'b0);
        chk("midrst.cnt0", cnt0, 4'd0);
        chk("midrst.cnt1", cnt1, 4'd0);
        chk("midrst.rsp_result", rsp_result, 32'h0);
        chk("midrst.r0_ready", r0_ready, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        rsp_ready = 1'b1;
        req1(1'b1, 32'd9, 32'd9, 4'h2);
        #1;
        chk("postrst.r0_ready", r0_ready, 1'b1);
        chk("postrst.r1_ready", r1_ready, 1'b0);
        @(negedge clk);
        chk_rsp("postrst", 1'b0, 32'd5, 1'b0, 1'b0);
        #1;
        chk("postrst2.r1_ready", r1_ready, 1'b1);
        @(negedge clk);
        chk_rsp("postrst2", 1'b1, 32'd18, 1'b0, 1'b0);
        req0(1'b0, '0, '0, 4'h0);
        req1(1'b0, '0, '0, 4'h0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
